series_exp_controller: RTL and testbench

Sequencing controller that evaluates the truncated series e^x ≈ Σ_{n=0..NUM_TERMS} x^n/n! on one shared registered multiply stage. Each term is formed iteratively as term_n = (term_{n-1}·x)·(1/n), with 1/n taken from a constant LUT. The block sits between an operand source and a result sink, both using valid/ready handshakes. It owns operand muxing, the term counter, the accumulator and the sticky overflow/saturation logic.

---
 rtl/series_exp_controller_pkg.sv | 58 +++++
 rtl/series_exp_controller_if.sv | 20 ++
 rtl/series_exp_controller_mul_stage.sv | 46 ++++
 rtl/series_exp_controller.sv | 129 ++++++++++++
 tb/tb_series_exp_controller.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/series_exp_controller_pkg.sv
// Shared definitions for the e^x series controller: state encodings, fixed-point
// constants, the reciprocal LUT generator and the saturating 32-bit adder.
package series_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_MX   = 3'd1;
   localparam state_t ST_MC   = 3'd2;
   localparam state_t ST_ACC  = 3'd3;
   localparam state_t ST_DONE = 3'd4;

   localparam int DEFAULT_FRAC_BITS = 16;
   localparam logic signed [31:0] ONE = 32'sd1 <<< DEFAULT_FRAC_BITS;

   localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;

   typedef struct packed {
      logic signed [31:0] value;
      logic               sat;
   } sat_add_t;

   // 1.0 in a Q(32-frac_bits).frac_bits format.
   function automatic logic signed [31:0] one_fixed(input int frac_bits);
      return 32'sd1 <<< frac_bits;
   endfunction

   // Round-to-nearest of 2^frac_bits / n; entry 0 is unused and reads as zero.
   function automatic logic signed [31:0] inv_lut(input int frac_bits, input logic [3:0] n);
      logic [63:0] num;
      logic [63:0] den;
      logic [63:0] quo;
      if (n == 4'd0) begin
         return '0;
      end
      den = {60'd0, n};
      num = (64'd1 << frac_bits) + (den >> 1);
      quo = num / den;
      return quo[31:0];
   endfunction

   function automatic sat_add_t sat_add(input logic signed [31:0] a, input logic signed [31:0] b);
      logic signed [32:0] s;
      sat_add_t           r;
      s     = {a[31], a} + {b[31], b};
      r.sat = (s[32] != s[31]);
      if (!r.sat) begin
         r.value = s[31:0];
      end else if (s[32]) begin
         r.value = SAT_MIN;
      end else begin
         r.value = SAT_MAX;
      end
      return r;
   endfunction

endpackage

// File: rtl/series_exp_controller_if.sv
// Operand-in / result-out handshake bundle for the series controller.
interface series_exp_controller_if;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] x;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] result;
   logic               overflow;

   modport master (
      output in_valid, x, out_ready,
      input  in_ready, out_valid, result, overflow
   );

   modport slave (
      input  in_valid, x, out_ready,
      output in_ready, out_valid, result, overflow
   );
endinterface

// File: rtl/series_exp_controller_mul_stage.sv
// Registered signed fixed-point multiply: full product, arithmetic shift by
// FRAC_BITS, saturate to 32 bits; the overflow strobe is aligned with q.
module series_mul_stage #(
   parameter int FRAC_BITS = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [31:0] a,
   input  logic signed [31:0] b,
   output logic signed [31:0] q,
   output logic               ovf
);
   import series_pkg::*;

   logic signed [63:0] prod;
   logic signed [63:0] shifted;
   logic signed [31:0] q_next;
   logic               ovf_next;
   logic               fits;

   always_comb begin
      // Low 64 bits of the product are sign-agnostic once operands are sign-extended.
      prod     = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      shifted  = prod >>> FRAC_BITS;
      fits     = (&shifted[63:31]) || (~|shifted[63:31]);
      ovf_next = !fits;
      if (fits) begin
         q_next = shifted[31:0];
      end else if (shifted[63]) begin
         q_next = SAT_MIN;
      end else begin
         q_next = SAT_MAX;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q   <= '0;
         ovf <= 1'b0;
      end else begin
         q   <= q_next;
         ovf <= ovf_next;
      end
   end

endmodule

// File: rtl/series_exp_controller.sv
// Sequences the truncated e^x series over one shared multiply stage:
// term_n = (term_{n-1} * x) * (1/n), summed with sticky overflow tracking.
module series_exp_controller
   import series_pkg::*;
#(
   parameter int NUM_TERMS = 8,
   parameter int FRAC_BITS = 16
) (
   input logic                    clk,
   input logic                    reset,
   series_exp_controller_if.slave bus
);

   localparam logic [3:0]         LAST_N    = 4'(NUM_TERMS);
   localparam logic signed [31:0] ONE_FIXED = one_fixed(FRAC_BITS);

   state_t             state_reg, state_next;
   logic signed [31:0] x_reg, x_next;
   logic signed [31:0] term_reg, term_next;
   logic signed [31:0] sum_reg, sum_next;
   logic [3:0]         n_reg, n_next;
   logic               ovf_reg, ovf_next;

   logic signed [31:0] mul_a, mul_b;
   logic signed [31:0] stage_q;
   logic               stage_ovf;
   sat_add_t           acc;

   logic signed [31:0] inv_table [16];

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_inv
         assign inv_table[gi] = inv_lut(FRAC_BITS, 4'(gi));
      end
   endgenerate

   series_mul_stage #(
      .FRAC_BITS(FRAC_BITS)
   ) u_mul (
      .clk  (clk),
      .reset(reset),
      .a    (mul_a),
      .b    (mul_b),
      .q    (stage_q),
      .ovf  (stage_ovf)
   );

   always_comb begin
      acc        = sat_add(sum_reg, stage_q);
      state_next = state_reg;
      x_next     = x_reg;
      term_next  = term_reg;
      sum_next   = sum_reg;
      n_next     = n_reg;
      ovf_next   = ovf_reg;
      mul_a      = '0;
      mul_b      = '0;

      case (state_reg)
         ST_IDLE: begin
            if (bus.in_valid) begin
               x_next     = bus.x;
               term_next  = ONE_FIXED;
               sum_next   = ONE_FIXED;
               n_next     = 4'd1;
               ovf_next   = 1'b0;
               state_next = ST_MX;
            end
         end
         ST_MX: begin
            mul_a      = term_reg;
            mul_b      = x_reg;
            state_next = ST_MC;
         end
         ST_MC: begin
            // stage_q now holds term*x; its strobe reports that product's saturation.
            mul_a      = stage_q;
            mul_b      = inv_table[n_reg];
            ovf_next   = ovf_reg | stage_ovf;
            state_next = ST_ACC;
         end
         ST_ACC: begin
            term_next = stage_q;
            sum_next  = acc.value;
            ovf_next  = ovf_reg | stage_ovf | acc.sat;
            if (n_reg == LAST_N) begin
               state_next = ST_DONE;
            end else begin
               n_next     = n_reg + 4'd1;
               state_next = ST_MX;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         x_reg     <= '0;
         term_reg  <= '0;
         sum_reg   <= '0;
         n_reg     <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         x_reg     <= x_next;
         term_reg  <= term_next;
         sum_reg   <= sum_next;
         n_reg     <= n_next;
         ovf_reg   <= ovf_next;
      end
   end

   // Outputs are gated by DONE so they read as zero outside a valid result.
   assign bus.in_ready  = (state_reg == ST_IDLE);
   assign bus.out_valid = (state_reg == ST_DONE);
   assign bus.result    = (state_reg == ST_DONE) ? sum_reg : '0;
   assign bus.overflow  = (state_reg == ST_DONE) && ovf_reg;

endmodule

// File: tb/tb_series_exp_controller.sv
// Directed bench for series_exp_controller: table of operands with hand-computed
// e^x partial sums, plus backpressure and mid-evaluation reset sequences.
module tb_series_exp_controller;

   localparam int NT      = 8;
   localparam int LATENCY = 3 * NT;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   series_exp_controller_if bus();

   series_exp_controller #(
      .NUM_TERMS(NT),
      .FRAC_BITS(16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] x;
      logic [31:0] exp_result;
      int          tol;
      logic        exp_ovf;
      string       name;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp, input int tol);
      longint d;
      checks++;
      d = longint'($signed(act)) - longint'($signed(exp));
      if (d < 0) d = -d;
      if (d > longint'(tol)) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (tol %0d)", name, act, exp, tol);
      end
   endtask

   task automatic accept(input string name, input logic [31:0] xv);
      check({name, "_in_ready_before"}, 32'(bus.in_ready), 32'd1, 0);
      bus.x        = xv;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.x        = $urandom;
   endtask

   // Counts edges from the accepting edge until out_valid, bounded.
   task automatic wait_done(input string name, output int lat);
      bit ready_low = 1'b1;
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         if (bus.in_ready) ready_low = 1'b0;
         tick();
         lat++;
      end
      check({name, "_latency"}, 32'(lat), 32'(LATENCY), 0);
      check({name, "_in_ready_low"}, 32'(ready_low && !bus.in_ready), 32'd1, 0);
   endtask

   task automatic handshake(input string name);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({name, "_in_ready_after"}, 32'(bus.in_ready), 32'd1, 0);
      check({name, "_out_valid_after"}, 32'(bus.out_valid), 32'd0, 0);
   endtask

   initial begin
      int          lat;
      logic [31:0] res;
      logic        ovf;
      bit          saw_valid;

      vecs[0] = '{32'h0000_0000, 32'h0001_0000, 0, 1'b0, "zero"};
      vecs[1] = '{32'h0001_0000, 32'h0002_B7E1, 8, 1'b0, "pos_one"};
      vecs[2] = '{32'hFFFF_0000, 32'h0000_5E2D, 8, 1'b0, "neg_one"};
      vecs[3] = '{32'h0020_0000, 32'h7FFF_FFFF, 0, 1'b1, "ovf_32"};
      vecs[4] = '{32'h0000_0000, 32'h0001_0000, 0, 1'b0, "zero_after_ovf"};
      vecs[5] = '{32'h0000_8000, 32'h0001_A613, 8, 1'b0, "half"};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.x         = '0;
      tick();
      tick();
      tick();
      reset = 1'b0;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1, 0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0, 0);
      check("rst_result", bus.result, 32'd0, 0);
      check("rst_overflow", 32'(bus.overflow), 32'd0, 0);

      for (int i = 0; i < 6; i++) begin
         accept(vecs[i].name, vecs[i].x);
         wait_done(vecs[i].name, lat);
         res = bus.result;
         ovf = bus.overflow;
         check({vecs[i].name, "_result"}, res, vecs[i].exp_result, vecs[i].tol);
         check({vecs[i].name, "_overflow"}, 32'(ovf), 32'(vecs[i].exp_ovf), 0);
         handshake(vecs[i].name);
         $display("txn %s: x=0x%08h result=0x%08h overflow=%0d latency=%0d",
                  vecs[i].name, vecs[i].x, res, ovf, lat);
      end

      // Backpressure: result held in DONE, stray in_valid pulses ignored.
      accept("bp", 32'h0001_0000);
      wait_done("bp", lat);
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = k[0];
         bus.x        = 32'h0020_0000;
         tick();
         check("bp_hold_out_valid", 32'(bus.out_valid), 32'd1, 0);
         check("bp_hold_result", bus.result, 32'h0002_B7E1, 8);
         check("bp_hold_overflow", 32'(bus.overflow), 32'd0, 0);
         check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0, 0);
      end
      $display("txn bp: result=0x%08h held 5 cycles", bus.result);

      // out_ready and in_valid together in DONE: new x waits for the IDLE cycle.
      bus.in_valid  = 1'b1;
      bus.x         = 32'h0000_0000;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("simul_in_ready", 32'(bus.in_ready), 32'd1, 0);
      check("simul_out_valid", 32'(bus.out_valid), 32'd0, 0);
      tick();
      bus.in_valid = 1'b0;
      check("simul_accepted", 32'(bus.in_ready), 32'd0, 0);
      wait_done("simul", lat);
      check("simul_result", bus.result, 32'h0001_0000, 0);
      check("simul_overflow", 32'(bus.overflow), 32'd0, 0);
      $display("txn simul: x=0x00000000 result=0x%08h latency=%0d", bus.result, lat);
      handshake("simul");

      // Reset while the controller sits in MC aborts the evaluation.
      accept("rst_mid", 32'h0001_0000);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1, 0);
      check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0, 0);
      check("rst_mid_result", bus.result, 32'd0, 0);
      check("rst_mid_overflow", 32'(bus.overflow), 32'd0, 0);
      saw_valid = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus.out_valid) saw_valid = 1'b1;
      end
      check("rst_mid_no_out_valid", 32'(saw_valid), 32'd0, 0);
      $display("txn rst_mid: evaluation aborted");

      accept("fresh", 32'h0001_0000);
      wait_done("fresh", lat);
      check("fresh_result", bus.result, 32'h0002_B7E1, 8);
      check("fresh_overflow", 32'(bus.overflow), 32'd0, 0);
      $display("txn fresh: x=0x00010000 result=0x%08h latency=%0d", bus.result, lat);
      handshake("fresh");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
